// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive path.
// Also usable by the transmitter for a common bit-timing convention.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitIdle = 3'd4
    } rx_state_e;

    localparam int unsigned DefaultDivisor = 416;

    // Clocks from start-edge detect to the middle of the start bit.
    function automatic logic [15:0] half_period(input int unsigned divisor);
        return 16'(divisor / 2);
    endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// Bit-period timer: free-running count that wraps on target, with a
// synchronous clear used to align the count to the start edge.
module uart_rx_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] target,
    output logic        next_bit
);

    logic [15:0] count_q, count_d;

    always_comb begin
        next_bit = !clear && (count_q == target);
        if (clear || next_bit) begin
            count_d = '0;
        end else begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, valid/re handshake and
// sticky framing-error / overrun status.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIVISOR = DefaultDivisor
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       valid,
    input  logic       re,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] HalfTarget = half_period(DIVISOR);
    localparam logic [15:0] BitTarget  = 16'(DIVISOR);

    logic        meta_q, rs_q, rs_prev_q;
    rx_state_e   state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_done_q, byte_done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic timer_clear, next_bit;
    logic frame_set, overrun_set, read_ack;

    uart_rx_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .target   (target_q),
        .next_bit (next_bit)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        rdata_d     = rdata_q;
        valid_d     = valid_q;
        frame_set   = 1'b0;
        // Holding the timer cleared while idle aligns it to the detected edge.
        timer_clear = (state_q == StIdle);

        unique case (state_q)
            StIdle: begin
                if (rs_prev_q && !rs_q) begin
                    target_d = HalfTarget;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (next_bit) begin
                    if (!rs_q) begin
                        target_d  = BitTarget;
                        bit_idx_d = '0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (next_bit) begin
                    shift_d   = {rs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (next_bit) begin
                    if (rs_q) begin
                        byte_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (rs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        read_ack    = re && valid_q;
        overrun_set = byte_done_q && valid_q && !re;
        if (read_ack) begin
            valid_d = 1'b0;
        end
        if (byte_done_q && (!valid_q || re)) begin
            rdata_d = shift_q;
            valid_d = 1'b1;
        end
        // A set in the same cycle as a read wins over the clear.
        frame_err_d = frame_set || (frame_err_q && !read_ack);
        overrun_d   = overrun_set || (overrun_q && !read_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q      <= 1'b1;
            rs_q        <= 1'b1;
            rs_prev_q   <= 1'b1;
            state_q     <= StIdle;
            target_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q      <= rx;
            rs_q        <= meta_q;
            rs_prev_q   <= rs_q;
            state_q     <= state_d;
            target_q    <= target_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rdata     = rdata_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with DIVISOR=15 (16 clocks per bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rdata;
    logic       valid;
    logic       re;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int fails  = 0;

    uart_rx #(.DIVISOR(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rdata     (rdata),
        .valid     (valid),
        .re        (re),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Drives one frame starting just after a clock edge. Iteration n drives
    // the line for edge n+1. The start edge seen at edge 2 puts the mid-start
    // sample at edge 11 and the stop sample at edge 155, so valid rises at 156.
    // re is high only for the cycle ending at edge re_at+1.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int re_at,
                              input int len, output int rise_at);
        logic [9:0] fr;
        logic       prev_valid;
        fr         = {stop_bit, b, 1'b0};
        rise_at    = -1;
        prev_valid = valid;
        for (int n = 0; n < len; n++) begin
            rx = fr[n / 16];
            re = (n == re_at);
            @(posedge clk);
            #1;
            if (rise_at < 0 && valid === 1'b1 && prev_valid !== 1'b1) rise_at = n + 1;
            prev_valid = valid;
        end
        re = 1'b0;
    endtask

    task automatic pulse_re();
        re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        re    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", rdata); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        reset = 1'b0;
        idle(10);
    endtask

    task automatic test_basic();
        int rise;
        send_frame(8'hA5, 1'b1, -1, 160, rise);
        checks++; if (rise !== 156) begin fails++; $display("FAIL basic_latency got %0d want 156", rise); end
        checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL basic_rdata got %h want a5", rdata); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL basic_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL basic_overrun got %b want 0", overrun); end
        pulse_re();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_ack got valid %b want 0", valid); end
        pulse_re();
        checks++; if (valid !== 1'b0 || rdata !== 8'hA5) begin
            fails++; $display("FAIL basic_idle_re got valid %b rdata %h want 0 a5", valid, rdata);
        end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int rise;
        send_frame(8'h00, 1'b1, -1, 160, rise);
        checks++; if (valid !== 1'b1 || rdata !== 8'h00) begin
            fails++; $display("FAIL b2b_first got valid %b rdata %h want 1 00", valid, rdata);
        end
        send_frame(8'hFF, 1'b1, -1, 160, rise);
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL b2b_rdata got %h want 00", rdata); end
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b want 1", overrun); end
        pulse_re();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_ack_valid got %b want 0", valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_ack_overrun got %b want 0", overrun); end
        idle(10);
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(200);
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL glitch_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL glitch_overrun got %b want 0", overrun); end
    endtask

    task automatic test_frame_error();
        int rise;
        send_frame(8'h3C, 1'b0, -1, 160, rise);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag got %b want 1", frame_err); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ferr_valid got %b want 0", valid); end
        idle(20);
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ferr_release got valid %b want 0", valid); end
        send_frame(8'h81, 1'b1, -1, 160, rise);
        checks++; if (rise !== 156) begin fails++; $display("FAIL ferr_next_latency got %0d want 156", rise); end
        checks++; if (rdata !== 8'h81) begin fails++; $display("FAIL ferr_next_rdata got %h want 81", rdata); end
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_sticky got %b want 1", frame_err); end
        pulse_re();
        checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++; $display("FAIL ferr_ack got valid %b frame_err %b want 0 0", valid, frame_err);
        end
        idle(10);
    endtask

    task automatic test_reset_mid_frame();
        int rise;
        send_frame(8'hC3, 1'b1, -1, 160, rise);
        send_frame(8'h5A, 1'b1, -1, 160, rise);
        checks++; if (overrun !== 1'b1 || rdata !== 8'hC3) begin
            fails++; $display("FAIL rst_setup got overrun %b rdata %h want 1 c3", overrun, rdata);
        end
        // 88 clocks in lands inside data bit 4.
        send_frame(8'h55, 1'b1, -1, 88, rise);
        reset = 1'b1;
        #1;
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_async_rdata got %h want 00", rdata); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid got %b want 0", valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_async_overrun got %b want 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_async_frame_err got %b want 0", frame_err); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(20);
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_no_partial got valid %b want 0", valid); end
        send_frame(8'h55, 1'b1, -1, 160, rise);
        checks++; if (rise !== 156) begin fails++; $display("FAIL rst_next_latency got %0d want 156", rise); end
        checks++; if (rdata !== 8'h55) begin fails++; $display("FAIL rst_next_rdata got %h want 55", rdata); end
        idle(10);
    endtask

    task automatic test_read_on_complete();
        int rise;
        // valid is still 1 holding 8'h55; re coincides with the acceptance cycle.
        send_frame(8'h12, 1'b1, 155, 160, rise);
        checks++; if (rdata !== 8'h12) begin fails++; $display("FAIL same_cycle_rdata got %h want 12", rdata); end
        checks++; if (valid !== 1'b1) begin fails++; $display("FAIL same_cycle_valid got %b want 1", valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL same_cycle_overrun got %b want 0", overrun); end
        pulse_re();
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL same_cycle_ack got %b want 0", valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_read_on_complete();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage; it is the downstream consumer of the UART transmitter's tx line, in loopback or from an external host.
- Converts an 8N1 asynchronous serial stream on rx into parallel bytes with a valid/ack handshake toward the CPU/bus side.
- Uses the same bit timing convention as the transmitter: one bit = DIVISOR+1 clocks, mid-bit sampling, LSB first.
- Reports framing errors and overruns as sticky status.

Parameters:
DIVISOR, 416, bit period minus one, in clk cycles (bit period = DIVISOR+1); must be >= 3.
HALF, DIVISOR/2 (integer divide), clocks from start-edge detect to mid-start-bit sample.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
rx  input  1  serial line, idle high, asynchronous to clk
rdata  output  8  last received byte; holds until the next accepted byte
valid  output  1  rdata holds an unread byte
re  input  1  read acknowledge; consumes the byte when valid=1
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a byte completed while valid=1 and re=0

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values:
  - rdata=8'h00, valid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1; state=IDLE; timer=0.
- Reset mid-frame: the frame is aborted and the receiver returns to IDLE with no partial byte.
- Synchroniser: two flops on rx (rs); a third flop (rs_d) for edge detect. rx-to-rs latency is 2 clocks.
- Timer (sub-module): 16-bit count. Cleared to 0 on clear. Otherwise it increments, and next_bit asserts when count==target, with count->0 on that cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rs_d=1 and rs=0, clear the timer, set target=HALF, go to START.
  - START: on next_bit, if rs=0, set target=DIVISOR, clear the bit index and go to DATA. If rs=1 (glitch), return to IDLE with no flag.
  - DATA: on each next_bit, shift rs into shift[7] with shift>>1 (LSB first) and increment the bit index. After the 8th sample, go to STOP.
  - STOP, on next_bit:
    - rs=1: complete the byte (see acceptance below) and go to IDLE.
    - rs=0: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rs=1, then go to IDLE. This prevents a break condition from producing spurious frames.
- Byte acceptance (cycle after the stop sample):
  - If valid=0, or valid=1 with re=1 in the same cycle: load rdata=shift and set valid=1.
  - If valid=1 and re=0: set overrun; rdata keeps the old byte and the new byte is dropped.
- Handshake:
  - re while valid=1 clears valid on the next edge.
  - re while valid=0 is ignored.
  - re while valid=1 also clears frame_err and overrun, unless the same cycle sets them; set wins.
- Latency: with an ideal start edge at clock T on rx:
  - Mid-start sample at T+2+1+HALF.
  - Each data sample follows DIVISOR+1 clocks after the previous sample.
  - valid rises one clock after the stop sample.
- A new start edge is only recognised in IDLE; the earliest new-frame detection is the clock after the stop sample.

Decomposition:
- Shared header uart_defs.vh:
  - FSM state localparams: IDLE=3'd0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
  - Default DIVISOR=416.
  - This header is also available to the transmitter.
- One sub-module, uart_rx_timer:
  - Ports: clk, reset, clear, target[15:0], next_bit.
  - Like the transmitter's free-running bit counter, but with async reset and a synchronous clear for start-edge alignment.
- Synchroniser, shift register and FSM stay in uart_rx.

Test Plan (DIVISOR=15, HALF=7, bit = 16 clocks):
- Send 8'hA5 8N1 with re held 0 -> valid rises 1 clk after the stop sample, rdata=8'hA5, frame_err=0, overrun=0; pulse re -> valid=0 the next clock.
- Send 8'h00 then 8'hFF back-to-back, no re -> rdata=8'h00, overrun=1 after the second stop; re -> valid=0, overrun=0.
- 5-clock low glitch on idle rx -> FSM returns to IDLE at the mid-start check; valid stays 0 and no flags set.
- Send 8'h3C with the stop bit driven low and held low for 40 clocks -> frame_err=1, valid=0, no byte until rx returns high; the following frame 8'h81 is received correctly.
- Assert reset during data bit 4 of 8'h55 -> all outputs return to reset values immediately (async); the next full frame 8'h55 is received correctly.
- valid=1 with re asserted in the exact cycle the next byte 8'h12 completes -> rdata=8'h12, valid stays 1, overrun=0.
